// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS-lite datapath.
//   DATA_W    : datapath word width
//   ADDR_W    : register address width
//   REG_ZERO  : hardwired-zero register index
//   REG_RA    : return-address register index (link target)
//   regaddr_t : register address type
//   word_t    : datapath word type
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] regaddr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam regaddr_t REG_ZERO = 5'd0;
    localparam regaddr_t REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_regfile_if.sv
// ---------------------------------------------------------------------------
// mips_regfile_if
// Bundle of the register-file read/write ports.
//   rs_addr/rs_data : read port A (feeds ALU operand a)
//   rt_addr/rt_data : read port B (feeds ALU operand-b mux / store data)
//   we/wr_addr/wr_data : general writeback port
//   link_we/link_data  : dedicated $ra link port
// Modports:
//   master : datapath side (drives addresses and writes, receives read data)
//   slave  : register file side
// ---------------------------------------------------------------------------
interface mips_regfile_if
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
);

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              link_we;
    logic [DATA_W-1:0] link_data;

    modport master (
        output rs_addr, rt_addr, we, wr_addr, wr_data, link_we, link_data,
        input  rs_data, rt_data
    );

    modport slave (
        input  rs_addr, rt_addr, we, wr_addr, wr_data, link_we, link_data,
        output rs_data, rt_data
    );

endinterface : mips_regfile_if

// File: rtl/mips_regfile_rdport.sv
// ---------------------------------------------------------------------------
// mips_regfile_rdport
// One combinational read port of the register file.
//   addr      : register index being read
//   stored    : current storage contents at addr
//   rd_data   : value presented to the datapath
// With REGFILE_BYPASS_EN defined, additional inputs describe the writes that
// commit on the coming edge (commit flags already exclude reset and the zero
// register) so the port can forward them in the same cycle:
//   gen_commit/gen_addr/gen_data    : general write port
//   link_commit/link_addr/link_data : link write port (wins over general)
// ---------------------------------------------------------------------------
module mips_regfile_rdport
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
)(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
    input  logic              gen_commit,
    input  logic [ADDR_W-1:0] gen_addr,
    input  logic [DATA_W-1:0] gen_data,
    input  logic              link_commit,
    input  logic [ADDR_W-1:0] link_addr,
    input  logic [DATA_W-1:0] link_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] rd_data_s;

    // Read mux: zero register first, then (optionally) forwarding, then storage.
    always_comb begin
        rd_data_s = '0;
        if (addr == ADDR_W'(REG_ZERO)) begin
            rd_data_s = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if ((link_commit == 1'b1) && (addr == link_addr)) begin
            rd_data_s = link_data;
        end
        else if ((gen_commit == 1'b1) && (addr == gen_addr)) begin
            rd_data_s = gen_data;
        end
`endif
        else begin
            rd_data_s = stored;
        end
    end

    assign rd_data = rd_data_s;

endmodule : mips_regfile_rdport

// File: rtl/mips_regfile.sv
// ---------------------------------------------------------------------------
// mips_regfile
// 32x32 general-purpose register file for the single-cycle MIPS-lite core.
// Two combinational read ports, one general write port and one dedicated
// link ($ra) write port. Register 0 reads as zero and is never written.
// When the general and link ports target the same register, the link wins.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all registers and
//         suppresses both write ports in that cycle
//   bus : mips_regfile_if.slave (read addresses/data, write ports)
// Build option:
//   REGFILE_BYPASS_EN : read ports forward data committing this cycle
// ---------------------------------------------------------------------------
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int LINK_REG = 31
)(
    input  logic           clk,
    input  logic           rst,
    mips_regfile_if.slave  bus
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic              gen_commit_s;
    logic              link_commit_s;

    // Enables qualify only when exactly 1 (an X enable evaluates false),
    // and nothing commits while reset is asserted.
    assign gen_commit_s  = (rst == 1'b0) && (bus.we == 1'b1) &&
                           (bus.wr_addr != ADDR_W'(REG_ZERO));
    assign link_commit_s = (rst == 1'b0) && (bus.link_we == 1'b1) &&
                           (LINK_ADDR != ADDR_W'(REG_ZERO));

    // Storage update: the link write is issued last so it overrides a
    // general write to the same register.
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (gen_commit_s) begin
                regs_r[bus.wr_addr] <= bus.wr_data;
            end
            if (link_commit_s) begin
                regs_r[LINK_ADDR] <= bus.link_data;
            end
        end
    end

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport_rs (
        .addr        (bus.rs_addr),
        .stored      (regs_r[bus.rs_addr]),
`ifdef REGFILE_BYPASS_EN
        .gen_commit  (gen_commit_s),
        .gen_addr    (bus.wr_addr),
        .gen_data    (bus.wr_data),
        .link_commit (link_commit_s),
        .link_addr   (LINK_ADDR),
        .link_data   (bus.link_data),
`endif
        .rd_data     (bus.rs_data)
    );

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport_rt (
        .addr        (bus.rt_addr),
        .stored      (regs_r[bus.rt_addr]),
`ifdef REGFILE_BYPASS_EN
        .gen_commit  (gen_commit_s),
        .gen_addr    (bus.wr_addr),
        .gen_data    (bus.wr_data),
        .link_commit (link_commit_s),
        .link_addr   (LINK_ADDR),
        .link_data   (bus.link_data),
`endif
        .rd_data     (bus.rt_data)
    );

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// ---------------------------------------------------------------------------
// tb_mips_regfile
// Self-checking bench for mips_regfile. Each cycle's expected read values
// are pushed to a scoreboard queue when the stimulus is driven and popped
// and compared when the outputs are sampled on the falling edge. A small
// reference model of the register file supplies the expectations, and the
// directed scenarios add fixed constants on top.
// ---------------------------------------------------------------------------
module tb_mips_regfile;

    logic clk;
    logic rst;

    mips_regfile_if bus ();

    mips_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          port;     // 0: rs_data, 1: rt_data
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          n_checks;
    int          n_fail;

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit port,
                            input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Reference read of the current cycle's inputs.
    function automatic logic [31:0] model_rd(input logic [4:0] a);
        logic [31:0] r;
        r = model[a];
        if (a == 5'd0) begin
            r = 32'd0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (rst == 1'b0 && bus.link_we == 1'b1 && a == 5'd31) begin
            r = bus.link_data;
        end
        else if (rst == 1'b0 && bus.we == 1'b1 && bus.wr_addr != 5'd0 &&
                 a == bus.wr_addr) begin
            r = bus.wr_data;
        end
`endif
        return r;
    endfunction

    // Drive one cycle, score its reads, then advance the model over the edge.
    task automatic step(input string tag, input logic r,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lw, input logic [31:0] ld,
                        input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        rst           = r;
        bus.we        = w;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.link_we   = lw;
        bus.link_data = ld;
        bus.rs_addr   = ra;
        bus.rt_addr   = rb;
        push_exp({tag, "_rs"}, 1'b0, model_rd(ra));
        push_exp({tag, "_rt"}, 1'b1, model_rd(rb));
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.port == 1'b0) check_eq(e.tag, bus.rs_data, e.val);
            else                check_eq(e.tag, bus.rt_data, e.val);
        end
        @(posedge clk);
        if (r == 1'b1) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else begin
            if (w == 1'b1 && wa != 5'd0) model[wa] = wd;
            if (lw == 1'b1) model[31] = ld;
        end
        #1;
    endtask

    logic [31:0] exp_same;
    logic [31:0] exp_coll;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst = 1'b1;
        bus.we = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
        bus.link_we = 1'b0; bus.link_data = 32'd0;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;

        // Reset, then read
        step("rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0);
        push_exp("rst_rd5", 1'b0, 32'd0);
        push_exp("rst_rd31", 1'b1, 32'd0);
        step("rst_rd", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd31);

        // Basic write / read, same-cycle visibility depends on bypass
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h1234_5678;
        exp_coll = 32'h0040_0010;
`else
        exp_same = 32'h0000_0000;
        exp_coll = 32'h0000_0000;
`endif
        push_exp("wr8_same", 1'b0, exp_same);
        step("wr8", 1'b0, 1'b1, 5'd8, 32'h1234_5678, 1'b0, 32'd0, 5'd8, 5'd0);
        push_exp("rd8_rs", 1'b0, 32'h1234_5678);
        push_exp("rd8_rt", 1'b1, 32'h1234_5678);
        step("rd8", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd8, 5'd8);

        // Zero register
        push_exp("wr0_same", 1'b0, 32'd0);
        step("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd0, 5'd0);
        push_exp("rd0", 1'b0, 32'd0);
        step("rd0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd8);

        // Collision on $ra: link wins
        push_exp("coll_same", 1'b0, exp_coll);
        step("coll", 1'b0, 1'b1, 5'd31, 32'hAAAA_0000, 1'b1, 32'h0040_0010, 5'd31, 5'd8);
        push_exp("coll_rd", 1'b0, 32'h0040_0010);
        step("coll_rd", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd31, 5'd0);

        // Dual commit
        step("dual", 1'b0, 1'b1, 5'd2, 32'd7, 1'b1, 32'h0000_0040, 5'd2, 5'd31);
        push_exp("dual_r2", 1'b0, 32'd7);
        push_exp("dual_r31", 1'b1, 32'h0000_0040);
        step("dual_rd", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd2, 5'd31);

        // Reset dominates a pending write
        step("wr9", 1'b0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'd0, 5'd0, 5'd0);
        push_exp("pre_r9", 1'b0, 32'h0000_0055);
        step("rd9", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd9, 5'd0);
        push_exp("rstwr_r9", 1'b0, 32'h0000_0055);
        step("rstwr", 1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 32'h1111_1111, 5'd9, 5'd31);
        push_exp("post_r9", 1'b0, 32'd0);
        push_exp("post_r31", 1'b1, 32'd0);
        step("post", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd9, 5'd31);

        // Random traffic checked against the model
        for (int k = 0; k < 300; k++) begin
            step("rnd",
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom(),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mips_regfile
